// File: rtl/register_file_32x32_if.sv
// Register-file access bundle: two read ports and one write port.
// The datapath side uses the master modport; the register file uses the slave modport.
interface register_file_32x32_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] read_addr1;
    logic [ADDR_WIDTH-1:0] read_addr2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output read_addr1, read_addr2, reg_write, write_addr, write_data,
        input  read_data1, read_data2
    );

    modport slave (
        input  read_addr1, read_addr2, reg_write, write_addr, write_data,
        output read_data1, read_data2
    );
endinterface

// File: rtl/register_file_32x32.sv
// Architectural register file of the single-cycle MIPS datapath.
// Two combinational read ports, one synchronous write port, $0 hard-wired to zero.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN -- when defined, a read of the
// register being written this cycle returns write_data combinationally.
module register_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    register_file_32x32_if.slave  rf
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    // A write to $0 is discarded so entry 0 never leaves its reset value.
    assign wr_en = rf.reg_write && (rf.write_addr != '0);

    // Next-state of the array: only the addressed entry takes the writeback value.
    always_comb begin
        // NOTE: default to the current contents first so no entry infers a latch.
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[rf.write_addr] = rf.write_data;
        end
    end

    // State update: synchronous reset clears every entry and overrides the write.
    always_ff @(posedge clk) begin
        // NOTE: the array is built from flops, so it is cleared in one edge like any
        // other register; a RAM macro could not offer that.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port 1: zero for $0, otherwise stored word (or same-cycle write-through).
    always_comb begin
        rd1 = mem_q[rf.read_addr1];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (!reset && wr_en && (rf.read_addr1 == rf.write_addr)) begin
            rd1 = rf.write_data;
        end
`endif
        if (rf.read_addr1 == '0) begin
            rd1 = '0;
        end
    end

    // Read port 2: identical structure to port 1.
    always_comb begin
        rd2 = mem_q[rf.read_addr2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (!reset && wr_en && (rf.read_addr2 == rf.write_addr)) begin
            rd2 = rf.write_data;
        end
`endif
        if (rf.read_addr2 == '0) begin
            rd2 = '0;
        end
    end

    assign rf.read_data1 = rd1;
    assign rf.read_data2 = rd2;
endmodule
